// File: rtl/fir_pkg.sv
// Shared constants and sample types for the serial FIR and its output formatter.
package fir_pkg;
  localparam int DIN_W      = 29;
  localparam int OUT_W      = 12;
  localparam int FRAME_LEN  = 8;
  localparam int COEF_SHIFT = 11;
  localparam int OUT_MAX    = 2047;
  localparam int OUT_MIN    = -2048;

  typedef logic signed [DIN_W-1:0] fir_acc_t;
  typedef logic signed [OUT_W-1:0] fir_smp_t;
endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous show-ahead FIFO; head shows the oldest entry, or the last popped value when empty.
module fir_sample_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [W-1:0]  last_q;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      last_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end
endmodule

// File: rtl/fir_out_formatter.sv
// Samples the FIR accumulator once per frame, rounds/scales/saturates it and queues
// the result for the serial-out stage with sticky clip and drop status.
module fir_out_formatter #(
  parameter int DIN_W        = fir_pkg::DIN_W,
  parameter int OUT_W        = fir_pkg::OUT_W,
  parameter int SHIFT        = fir_pkg::COEF_SHIFT,
  parameter int FRAME_LEN    = fir_pkg::FRAME_LEN,
  parameter int SAMPLE_PHASE = 3,
  parameter int DEPTH        = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIN_W-1:0]       din,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   sat_flag,
  output logic                   ovf_flag,
  input  logic                   clr_flags
);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic signed [DIN_W:0] RND   = (DIN_W+1)'(2**(SHIFT-1));
  localparam logic signed [DIN_W:0] Q_MAX = (DIN_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [DIN_W:0] Q_MIN = (DIN_W+1)'(-(2**(OUT_W-1)));

  logic [CNT_W-1:0]        frame_cnt;
  logic signed [DIN_W-1:0] cap_reg;
  logic                    cap_vld;
  logic signed [DIN_W:0]   rnd_sum;
  logic signed [DIN_W:0]   rnd_q;
  logic [OUT_W-1:0]        fmt_data;
  logic                    clip;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      cap_reg   <= '0;
      cap_vld   <= 1'b0;
    end else begin
      frame_cnt <= frame_cnt + 1'b1;
      cap_vld   <= (frame_cnt == CNT_W'(SAMPLE_PHASE));
      if (frame_cnt == CNT_W'(SAMPLE_PHASE)) cap_reg <= din;
    end
  end

  // One extra bit keeps the rounding add from wrapping at the positive rail.
  assign rnd_sum = {cap_reg[DIN_W-1], cap_reg} + RND;
  assign rnd_q   = rnd_sum >>> SHIFT;

  always_comb begin
    clip     = 1'b0;
    fmt_data = rnd_q[OUT_W-1:0];
    if (rnd_q > Q_MAX) begin
      clip     = 1'b1;
      fmt_data = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (rnd_q < Q_MIN) begin
      clip     = 1'b1;
      fmt_data = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  // Handshake: the head transfers on any edge where out_valid and out_ready are both high;
  // out_valid only reflects occupancy and never waits on out_ready.
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Set wins over a same-edge clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      sat_flag <= (sat_flag && !clr_flags) || (cap_vld && clip);
      ovf_flag <= (ovf_flag && !clr_flags) || (cap_vld && fifo_full && !pop);
    end
  end

  fir_sample_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cap_vld),
    .push_data (fmt_data),
    .pop       (out_ready),
    .head      (out_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
endmodule

// File: tb/tb_fir_out_formatter.sv
// Bench for fir_out_formatter: directed scenarios plus random traffic against a queue-based model.
module tb_fir_out_formatter;
  logic               clk = 1'b0;
  logic               rst;
  logic signed [28:0] din;
  logic [11:0]        out_data;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         fifo_level;
  logic               sat_flag;
  logic               ovf_flag;
  logic               clr_flags;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [11:0] exp_q[$];
  logic [11:0] last_out;
  int          ph;
  bit          pend;
  longint      pend_val;
  bit          m_sat;
  bit          m_ovf;

  fir_out_formatter dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .sat_flag   (sat_flag),
    .ovf_flag   (ovf_flag),
    .clr_flags  (clr_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Round half up, divide by 2^11 with floor, clip to the 12-bit signed range.
  function automatic logic [11:0] fmt(input longint x, output bit clip);
    longint r, q;
    r = x + 1024;
    q = (r >= 0) ? r / 2048 : -((-r + 2047) / 2048);
    clip = 1'b0;
    if (q > 2047) begin q = 2047; clip = 1'b1; end
    if (q < -2048) begin q = -2048; clip = 1'b1; end
    return 12'(q);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last_out = '0;
    ph       = 0;
    pend     = 1'b0;
    pend_val = 0;
    m_sat    = 1'b0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_step(input longint d, input bit r, input bit c);
    bit          was_full, pop, clip, sat_set, ovf_set;
    logic [11:0] v;
    was_full = (exp_q.size() == 4);
    pop      = (exp_q.size() > 0) && r;
    sat_set  = 1'b0;
    ovf_set  = 1'b0;
    if (pop) last_out = exp_q.pop_front();
    if (pend) begin
      v       = fmt(pend_val, clip);
      sat_set = clip;
      if (!was_full || pop) exp_q.push_back(v);
      else ovf_set = 1'b1;
    end
    m_sat = (m_sat && !c) || sat_set;
    m_ovf = (m_ovf && !c) || ovf_set;
    pend  = (ph == 3);
    if (pend) pend_val = d;
    ph = (ph + 1) % 8;
  endtask

  task automatic compare();
    logic [11:0] h;
    h = (exp_q.size() > 0) ? exp_q[0] : last_out;
    check("out_valid", out_valid, exp_q.size() > 0);
    check("out_data", longint'($signed(out_data)), longint'($signed(h)));
    check("fifo_level", fifo_level, exp_q.size());
    check("sat_flag", sat_flag, m_sat);
    check("ovf_flag", ovf_flag, m_ovf);
  endtask

  // Driver: called at a falling edge, applies inputs, steps one rising edge, returns at the next falling edge.
  task automatic cyc(input logic signed [28:0] d, input bit r, input bit c);
    din       = d;
    out_ready = r;
    clr_flags = c;
    @(posedge clk);
    model_step(longint'(d), r, c);
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic align();
    while (ph != 0) cyc('0, 1'b1, 1'b0);
  endtask

  task automatic frame(input logic signed [28:0] d, input bit r);
    align();
    for (int i = 0; i < 8; i++) cyc(d, r, 1'b0);
  endtask

  longint rv[5] = '{4096, 1023, 1024, -1024, -1025};
  longint re[5] = '{2, 0, 1, 0, -1};

  initial begin
    int ready_pct;
    logic signed [28:0] d;
    rst = 1'b1; din = '0; out_ready = 1'b0; clr_flags = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_ovf", ovf_flag, 0);
    @(negedge clk);
    rst = 1'b0;

    // rounding
    for (int i = 0; i < 5; i++) begin
      frame(29'(rv[i]), 1'b1);
      check("round_out", longint'($signed(out_data)), re[i]);
      check("round_sat", sat_flag, 0);
    end

    // saturation and flag clearing
    frame(29'sd8388608, 1'b1);
    check("sat_hi", longint'($signed(out_data)), 2047);
    check("sat_hi_flag", sat_flag, 1);
    frame(-29'sd8388608, 1'b1);
    check("sat_lo", longint'($signed(out_data)), -2048);
    cyc('0, 1'b1, 1'b1);
    check("sat_clr", sat_flag, 0);
    align();
    for (int i = 0; i < 8; i++) cyc(29'sd8388608, 1'b1, (ph == 3) || (ph == 4));
    check("sat_set_wins", sat_flag, 1);

    // phase selectivity
    for (int i = 0; i < 8; i++) cyc((i == 1 || i == 2) ? 29'sd500000 : 29'sd0, 1'b1, 1'b0);
    check("phase_sel", longint'($signed(out_data)), 0);
    cyc('0, 1'b1, 1'b1);

    // overflow
    for (int k = 1; k <= 5; k++) frame(29'(2048 * k), 1'b0);
    check("ovf_level", fifo_level, 4);
    check("ovf_flag_set", ovf_flag, 1);
    for (int k = 1; k <= 4; k++) begin
      check("ovf_order", longint'($signed(out_data)), k);
      cyc('0, 1'b1, 1'b0);
    end
    align();
    cyc('0, 1'b1, 1'b1);

    // full FIFO with push and pop on the same edge
    for (int k = 1; k <= 4; k++) frame(29'(2048 * k), 1'b0);
    for (int i = 0; i < 8; i++) cyc(29'(2048 * 5), ph == 4, 1'b0);
    check("pp_level", fifo_level, 4);
    check("pp_ovf", ovf_flag, 0);
    for (int k = 2; k <= 5; k++) begin
      check("pp_order", longint'($signed(out_data)), k);
      cyc('0, 1'b1, 1'b0);
    end

    // asynchronous reset with entries queued
    frame(29'sd8388608, 1'b0);
    frame(29'sd2048, 1'b0);
    frame(29'sd4096, 1'b0);
    check("pre_rst_level", fifo_level, 3);
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_level", fifo_level, 0);
    check("arst_sat", sat_flag, 0);
    check("arst_ovf", ovf_flag, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(29'sd4096, 1'b0, 1'b0);
    check("post_rst_empty", out_valid, 0);
    cyc(29'sd4096, 1'b0, 1'b0);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", longint'($signed(out_data)), 2);

    // random traffic
    ready_pct = 50;
    for (int n = 0; n < 600; n++) begin
      if (n % 64 == 0) ready_pct = (n / 64) % 3 == 0 ? 10 : ((n / 64) % 3 == 1 ? 50 : 95);
      case ($urandom_range(0, 2))
        0: d = 29'(longint'($urandom_range(0, 16383)) - 8192);
        1: d = 29'((longint'($urandom_range(0, 4200)) - 2100) * 2048 + 1024);
        default: d = 29'($urandom);
      endcase
      cyc(d, $urandom_range(0, 99) < ready_pct, $urandom_range(0, 29) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fir_out_formatter.md
Name: fir_out_formatter

Overview:
- Downstream stage of the serial 16-tap FIR.
- Samples the FIR's 29-bit accumulated output once per 8-clock frame.
- Rounds and scales the sample, then saturates it to 12 bits.
- Buffers results in a small FIFO and presents them to the DAC/serial-out stage over a valid/ready handshake, with sticky saturation and overflow status.

Parameters:
- DIN_W, 29, width of the FIR output word.
- OUT_W, 12, width of the formatted output sample.
- SHIFT, 11, arithmetic right-shift applied after rounding (≥1). Removes the Q11 coefficient gain.
- FRAME_LEN, 8, clocks per input sample. Must be a power of 2; matches the FIR's 3-bit frame counter.
- SAMPLE_PHASE, 3, frame-counter value at which din is captured. The FIR output register is stable at this phase.
- DEPTH, 4, FIFO entries. Must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock (16 kHz); same clock as the FIR.
- rst  in  1  asynchronous, active-high reset. Shared with the FIR so the frame counters stay aligned.
- din  in  DIN_W  signed FIR output (Yout).
- out_data  out  OUT_W  signed FIFO head sample.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when high together with out_valid.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- sat_flag  out  1  sticky: at least one sample clipped.
- ovf_flag  out  1  sticky: at least one sample dropped on a full FIFO.
- clr_flags  in  1  synchronous clear of sat_flag and ovf_flag.

Behaviour:
- Reset (async, rst=1): frame counter=0, capture stage empty, FIFO empty. Reset values: out_valid=0, out_data=0, fifo_level=0, sat_flag=0, ovf_flag=0. A reset mid-frame or mid-burst discards all buffered samples. After release, counting restarts at 0 in lockstep with the FIR.
- Frame counter: free-running, modulo FRAME_LEN, increments every clk.
- Capture (edge E0): at the edge where counter==SAMPLE_PHASE, din is registered into cap_reg and cap_vld pulses for exactly 1 cycle. din is never sampled at any other phase.
- Format (combinational on cap_reg):
  - r = cap_reg + 2^(SHIFT-1), computed at DIN_W+1 bits (no wrap).
  - q = r >>> SHIFT. This is round-half-up, i.e. toward +inf on ties.
  - If q > 2^(OUT_W-1)-1, output 2047 and set sat_flag.
  - If q < -2^(OUT_W-1), output -2048 and set sat_flag.
  - Otherwise output q[OUT_W-1:0].
- Write (edge E1, the edge following E0): the formatted value is pushed into the FIFO. out_valid and out_data are visible after E1. Latency is 2 clk edges from capture to visible output when the FIFO is empty.
- FIFO: show-ahead, out_data = head entry.
  - Pop when out_valid && out_ready.
  - Push when cap_vld.
- Full FIFO:
  - Push without a same-cycle pop: the new sample is dropped, ovf_flag is set, and contents are unchanged.
  - Push with a same-cycle pop: both occur, fifo_level stays DEPTH, no drop.
- Empty FIFO: out_ready has no effect. out_data holds its last value (0 after reset).
- Pointers wrap modulo DEPTH. fifo_level is never above DEPTH and never negative.
- Flags: a clear on the same edge as a new set event leaves the flag set (set wins). Flags do not affect the datapath.
- Throughput: at most one push per FRAME_LEN clocks, so a consumer that keeps out_ready high never causes overflow.

Decomposition:
- Shared package fir_pkg:
  - constants DIN_W=29, OUT_W=12, FRAME_LEN=8, COEF_SHIFT=11, OUT_MAX=2047, OUT_MIN=-2048;
  - typedefs fir_acc_t (signed [28:0]) and fir_smp_t (signed [11:0]).
- One sub-module: fir_sample_fifo. This is a parameterised synchronous show-ahead FIFO with push, pop, level, full and empty. It has no flag logic.
- The top holds the frame counter, capture, round/saturate and sticky flags.

Test Plan:
- Rounding, out_ready=1, one din value per frame, each applied at SAMPLE_PHASE: 4096, 1023, 1024, -1024, -1025 → out_data 2, 0, 1, 0, -1. Each value appears 2 edges after its capture, and sat_flag stays 0.
- Saturation: din=8388608 → 2047, sat_flag=1. din=-8388608 → -2048. clr_flags pulse → sat_flag=0. Same-edge clr_flags plus a clipping capture → sat_flag stays 1.
- Phase selectivity: din changes to 500000 at a non-capture phase and returns to 0 before SAMPLE_PHASE → no output change (0 pushed).
- Overflow: out_ready=0 for 5 frames with din = 2048·k, k=1..5 → fifo_level=4, ovf_flag=1. Pops then yield 1, 2, 3, 4; the 5th sample is lost.
- Full push+pop: FIFO full, out_ready=1 exactly on the push cycle → fifo_level stays 4, ovf_flag=0, order preserved.
- Reset mid-operation: assert rst with 3 entries queued → out_valid=0, fifo_level=0, and flags cleared immediately (async). The first capture after release occurs at counter==3.
